// File: rtl/lsu_mem_responder_if.sv
// Word-wide data memory port between the load/store responder and the memory.
// The responder drives the request side; the memory drives ready and read data.
interface lsu_mem_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_responder.sv
// RV32I load/store responder: steers store lanes, extends load data and stalls
// the core while a variable-latency word memory completes, with timeout abort.
module lsu_mem_responder #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       MemRead,
  input  logic                       MemWrite,
  input  logic [2:0]                 funct3,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       stall,
  output logic                       misaligned,
  output logic                       access_err,
  lsu_mem_responder_if.master        mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int unsigned    CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  state_t      state;
  logic [CW-1:0] wait_cnt;
  logic        timed_out;
  logic [31:0] rdata_q;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;

  logic        req;
  logic        illegal;
  logic        unaligned;
  logic        accept;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    req       = MemRead ^ MemWrite;
    illegal   = MemRead & MemWrite;
    unaligned = 1'b0;
    wstrb_n   = 4'b0000;
    wdata_n   = 32'h0;
    if (req) begin
      case (funct3)
        3'b000: begin
          wstrb_n = 4'b0001 << addr[1:0];
          wdata_n = {4{wdata[7:0]}};
        end
        3'b001: begin
          unaligned = addr[0];
          wstrb_n   = 4'b0011 << {addr[1], 1'b0};
          wdata_n   = {2{wdata[15:0]}};
        end
        3'b010: begin
          unaligned = |addr[1:0];
          wstrb_n   = 4'b1111;
          wdata_n   = wdata;
        end
        3'b100:  illegal = MemWrite;
        3'b101: begin
          unaligned = addr[0];
          illegal   = MemWrite;
        end
        default: illegal = 1'b1;
      endcase
      if (!MemWrite) begin
        wstrb_n = 4'b0000;
        wdata_n = 32'h0;
      end
    end
    accept = req & ~illegal & ~unaligned;
  end

  // Rejections are reported combinationally and never reach the memory.
  assign stall      = (state == REQ) | ((state == IDLE) & accept);
  assign misaligned = (state == IDLE) & req & ~illegal & unaligned;
  assign access_err = ((state == IDLE) & illegal) | ((state == DONE) & timed_out);
  assign rdata      = (state == DONE) ? rdata_q : 32'h0;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      timed_out     <= 1'b0;
      rdata_q       <= 32'h0;
      lane_q        <= 2'b00;
      funct3_q      <= 3'b000;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wstrb <= 4'b0000;
      mem.mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= MemWrite;
            mem.mem_addr  <= {addr[31:2], 2'b00};
            mem.mem_wstrb <= wstrb_n;
            mem.mem_wdata <= wdata_n;
            lane_q        <= addr[1:0];
            funct3_q      <= funct3;
            wait_cnt      <= '0;
            timed_out     <= 1'b0;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_ready || (wait_cnt == LAST)) begin
            // Completion or abort: bus returns to idle-zero before DONE.
            rdata_q       <= (mem.mem_ready && !mem.mem_we) ?
                             load_extract(mem.mem_rdata, lane_q, funct3_q) : 32'h0;
            timed_out     <= ~mem.mem_ready;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wstrb <= 4'b0000;
            mem.mem_wdata <= 32'h0;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          rdata_q   <= 32'h0;
          timed_out <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Self-checking bench for lsu_mem_responder: directed plan cases plus random
// accesses checked against an arithmetic model of lane steering and extension.
module tb_lsu_mem_responder;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misaligned, access_err;

  lsu_mem_responder_if mem();

  lsu_mem_responder #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misaligned (misaligned),
    .access_err (access_err),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f);
    case (f[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_illegal(input bit rd, input bit wr, input logic [2:0] f);
    if (rd && wr) return 1'b1;
    if (!(rd ^ wr)) return 1'b0;
    if (wr) return (f > 3'd2);
    return !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic bit model_misaligned(input logic [31:0] a, input logic [2:0] f);
    return (int'(a[1:0]) % size_of(f)) != 0;
  endfunction

  function automatic logic [3:0] model_strobe(input logic [31:0] a, input logic [2:0] f);
    int n   = size_of(f);
    int off = (int'(a[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] f);
    logic [31:0] res;
    int n = size_of(f);
    for (int i = 0; i < 4; i++) res[8*i +: 8] = wd[8*(i % n) +: 8];
    return res;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] f);
    int n = size_of(f);
    logic [31:0] v, mask;
    if (n == 4) return w;
    v    = w >> (8 * int'(a[1:0]));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (!f[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_step(input string name);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    mem.mem_ready = 1'($urandom_range(0, 1));
    mem.mem_rdata = $urandom;
    #1;
    check({name, ".idle_data"}, rdata | mem.mem_addr | mem.mem_wdata, 32'h0);
    check({name, ".idle_flags"},
          {27'h0, stall, misaligned, access_err, mem.mem_req, mem.mem_we} | {28'h0, mem.mem_wstrb},
          32'h0);
  endtask

  task automatic access(input string name, input bit rd, input bit wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rword, input int lat);
    bit ill, mis, to, done;
    int k, stalled;
    ill = model_illegal(rd, wr, f);
    mis = !ill && model_misaligned(a, f);

    @(negedge clk);
    MemRead = rd; MemWrite = wr; funct3 = f; addr = a; wdata = wd;
    mem.mem_ready = 1'($urandom_range(0, 1));
    mem.mem_rdata = $urandom;
    #1;
    check({name, ".stall_idle"}, stall, (ill || mis) ? 1'b0 : 1'b1);
    check({name, ".misaligned"}, misaligned, mis);
    check({name, ".access_err"}, access_err, ill);
    check({name, ".req_idle"}, mem.mem_req, 1'b0);
    stalled = stall ? 1 : 0;

    if (ill || mis) begin
      @(negedge clk); #1;
      check({name, ".rej_req_held"}, mem.mem_req, 1'b0);
      check({name, ".rej_stall_held"}, stall, 1'b0);
      idle_step(name);
      return;
    end

    k = 0; done = 1'b0; to = 1'b0;
    while (!done) begin
      @(negedge clk);
      k++;
      mem.mem_ready = (k == lat);
      mem.mem_rdata = (k == lat) ? rword : $urandom;
      #1;
      check({name, ".req"},   mem.mem_req, 1'b1);
      check({name, ".we"},    mem.mem_we, wr);
      check({name, ".addr"},  mem.mem_addr, {a[31:2], 2'b00});
      check({name, ".wstrb"}, mem.mem_wstrb, wr ? model_strobe(a, f) : 4'b0000);
      if (wr) check({name, ".wdata"}, mem.mem_wdata, model_wdata(wd, f));
      if (stall) stalled++;
      if (k == lat) done = 1'b1;
      else if (k == TIMEOUT) begin done = 1'b1; to = 1'b1; end
    end

    @(negedge clk);
    mem.mem_ready = 1'($urandom_range(0, 1));
    mem.mem_rdata = $urandom;
    #1;
    check({name, ".done_stall"}, stall, 1'b0);
    check({name, ".done_req"},   mem.mem_req, 1'b0);
    check({name, ".done_err"},   access_err, to);
    check({name, ".rdata"},      rdata, (to || wr) ? 32'h0 : model_load(rword, a, f));
    check({name, ".stall_cycles"}, stalled, 1 + ((lat < TIMEOUT) ? lat : TIMEOUT));
    idle_step(name);
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem.mem_ready = 1'b0; mem.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.data", rdata | mem.mem_addr | mem.mem_wdata, 32'h0);
    check("reset.flags", {stall, misaligned, access_err, mem.mem_req, mem.mem_we, mem.mem_wstrb}, 9'h0);
    rst = 1'b0;
    idle_step("post_reset");

    // Directed plan cases
    access("sw_zero_lat", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    access("lb",          1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 1);
    access("lbu",         1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 1);
    access("sh",          1'b0, 1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 2);
    access("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 1);
    access("rd_and_wr",   1'b1, 1'b1, 3'b010, 32'h400, 32'h0, 32'h0, 1);
    access("shu_illegal", 1'b0, 1'b1, 3'b101, 32'h401, 32'h0, 32'h0, 1);
    access("lhu_wait",    1'b1, 1'b0, 3'b101, 32'h500, 32'h0, 32'h1234F00D, 5);
    access("lw_timeout",  1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 32'h0, TIMEOUT + 10);
    access("lh_at_limit", 1'b1, 1'b0, 3'b001, 32'h802, 32'h0, 32'h8001CAFE, TIMEOUT);

    // Reset in the third REQ cycle aborts the access silently
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h600; mem.mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      mem.mem_ready = 1'b0;
    end
    #1;
    check("rst_mid.in_req", mem.mem_req, 1'b1);
    rst = 1'b1; MemRead = 1'b0;
    @(negedge clk); #1;
    check("rst_mid.req",   mem.mem_req, 1'b0);
    check("rst_mid.stall", stall, 1'b0);
    check("rst_mid.err",   access_err, 1'b0);
    check("rst_mid.rdata", rdata, 32'h0);
    rst = 1'b0;
    idle_step("rst_mid");
    access("sw_after_rst", 1'b0, 1'b1, 3'b010, 32'h604, 32'h0BADF00D, 32'h0, 2);

    // Random mix of loads, stores, rejects, wait states and timeouts
    for (int i = 0; i < 40; i++) begin
      int sel;
      bit rd, wr;
      sel = $urandom_range(0, 9);
      rd  = (sel <= 5);
      wr  = (sel == 0) || (sel >= 6);
      access("rand", rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(1, TIMEOUT + 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
